// File: rtl/sprite_anim_ctrl.sv
// -----------------------------------------------------------------------------
// sprite_anim_ctrl
//
// Purpose:
//   Drives the sprite frame-select mux. From the held button levels it produces
//   the 2-bit direction code and 2-bit walk step that pick one of 16 sprite
//   frames, and it tracks the sprite's on-screen position. All state advances
//   only on frame_tick, so the animation and position never change mid-frame.
//
// Ports:
//   clk         in   1   pixel/system clock
//   reset       in   1   asynchronous, active-high reset
//   frame_tick  in   1   one-cycle pulse per VGA frame
//   btn         in   4   {up,down,left,right} held levels, already synchronised
//   pause       in   1   freeze request (only when SPRITE_ANIM_PAUSE_EN is defined)
//   dir         out  2   0 UP, 1 DOWN, 2 LEFT, 3 RIGHT
//   step        out  2   walk step 0..3
//   moving      out  1   high while walking
//   step_adv    out  1   one-cycle pulse in the cycle after step increments
//   pos_x       out  CW  sprite left edge, 0..X_MAX
//   pos_y       out  CW  sprite top edge, 0..Y_MAX
//
// Build option:
//   SPRITE_ANIM_PAUSE_EN - adds the pause port; a tick seen with pause=1 is
//   ignored entirely. Without it every frame_tick is processed.
// -----------------------------------------------------------------------------
module sprite_anim_ctrl #(
    parameter int TICKS_PER_STEP = 8,
    parameter int SPEED          = 2,
    parameter int CW             = 10,
    parameter int X_MAX          = 608,
    parameter int Y_MAX          = 448,
    parameter int X_INIT         = 304,
    parameter int Y_INIT         = 224
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          frame_tick,
    input  logic [3:0]    btn,
`ifdef SPRITE_ANIM_PAUSE_EN
    input  logic          pause,
`endif
    output logic [1:0]    dir,
    output logic [1:0]    step,
    output logic          moving,
    output logic          step_adv,
    output logic [CW-1:0] pos_x,
    output logic [CW-1:0] pos_y
);

    localparam int CNT_W = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICKS_PER_STEP - 1);
    // The tick that starts (or restarts) a walk is itself the first tick of
    // the step period, so the counter starts at 1. With a one-tick period
    // there is nothing to pre-count.
    localparam logic [CNT_W-1:0] CNT_ENTRY = CNT_W'((TICKS_PER_STEP > 1) ? 1 : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WALK   = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       dir_q, dir_d;
    logic [1:0]       step_q, step_d;
    logic             moving_q, moving_d;
    logic             step_adv_q, step_adv_d;
    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [CW-1:0]    pos_x_q, pos_x_d;
    logic [CW-1:0]    pos_y_q, pos_y_d;

    logic             tick_en;
    logic             req_valid;
    logic [1:0]       req_dir;
    logic             anim_wrap;
    logic [CNT_W-1:0] anim_cnt;
    logic [1:0]       anim_step;
    logic [CW-1:0]    moved_x, moved_y;
    logic [CW:0]      x_inc, x_dec, y_inc, y_dec;
    logic             do_enter, do_anim, do_move;

`ifdef SPRITE_ANIM_PAUSE_EN
    assign tick_en = frame_tick & ~pause;
`else
    assign tick_en = frame_tick;
`endif

    // Requested direction, priority UP > DOWN > LEFT > RIGHT.
    assign req_valid = |btn;
    always_comb begin
        req_dir = 2'd3;
        if (btn[3])      req_dir = 2'd0;
        else if (btn[2]) req_dir = 2'd1;
        else if (btn[1]) req_dir = 2'd2;
        else             req_dir = 2'd3;
    end

    // Step-period counter: one advance every TICKS_PER_STEP animated ticks.
    assign anim_wrap = (tick_cnt_q == CNT_LAST);
    assign anim_cnt  = anim_wrap ? '0 : tick_cnt_q + CNT_W'(1);
    assign anim_step = anim_wrap ? step_q + 2'd1 : step_q;

    // One SPEED step in the requested direction, computed one bit wider so
    // underflow and overflow are visible before clamping.
    assign x_inc = {1'b0, pos_x_q} + (CW+1)'(SPEED);
    assign x_dec = {1'b0, pos_x_q} - (CW+1)'(SPEED);
    assign y_inc = {1'b0, pos_y_q} + (CW+1)'(SPEED);
    assign y_dec = {1'b0, pos_y_q} - (CW+1)'(SPEED);

    always_comb begin
        moved_x = pos_x_q;
        moved_y = pos_y_q;
        case (req_dir)
            2'd0: moved_y = ({1'b0, pos_y_q} < (CW+1)'(SPEED)) ? '0 : y_dec[CW-1:0];
            2'd1: moved_y = (y_inc > (CW+1)'(Y_MAX)) ? CW'(Y_MAX) : y_inc[CW-1:0];
            2'd2: moved_x = ({1'b0, pos_x_q} < (CW+1)'(SPEED)) ? '0 : x_dec[CW-1:0];
            default: moved_x = (x_inc > (CW+1)'(X_MAX)) ? CW'(X_MAX) : x_inc[CW-1:0];
        endcase
    end

    // Next-state logic. do_enter starts a fresh walk in the requested
    // direction; do_anim advances the step counter; do_move applies movement.
    always_comb begin
        state_d  = state_q;
        do_enter = 1'b0;
        do_anim  = 1'b0;
        do_move  = 1'b0;
        if (tick_en) begin
            case (state_q)
                IDLE: begin
                    if (req_valid) do_enter = 1'b1;
                end
                WALK: begin
                    if (!req_valid) begin
                        // Release mid-stride: this tick already counts toward
                        // finishing the stride back to the stance frame.
                        if (step_q != 2'd0) begin
                            do_anim = 1'b1;
                            state_d = SETTLE;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (req_dir != dir_q) begin
                        do_enter = 1'b1;
                    end else begin
                        do_anim = 1'b1;
                        do_move = 1'b1;
                    end
                end
                SETTLE: begin
                    if (req_valid) do_enter = 1'b1;
                    else           do_anim  = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end

        if (do_enter) state_d = WALK;
        // Stride finished (step wrapped back to 0) with no button held.
        if (do_anim && !req_valid && anim_wrap && step_q == 2'd3) state_d = IDLE;

        dir_d      = do_enter ? req_dir : dir_q;
        step_d     = do_enter ? 2'd0 : (do_anim ? anim_step : step_q);
        tick_cnt_d = do_enter ? CNT_ENTRY : (do_anim ? anim_cnt : tick_cnt_q);
        step_adv_d = do_anim & anim_wrap;
        pos_x_d    = (do_enter || do_move) ? moved_x : pos_x_q;
        pos_y_d    = (do_enter || do_move) ? moved_y : pos_y_q;
        moving_d   = (state_d == WALK);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            dir_q      <= 2'd1;
            step_q     <= 2'd0;
            moving_q   <= 1'b0;
            step_adv_q <= 1'b0;
            tick_cnt_q <= '0;
            pos_x_q    <= CW'(X_INIT);
            pos_y_q    <= CW'(Y_INIT);
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            step_q     <= step_d;
            moving_q   <= moving_d;
            step_adv_q <= step_adv_d;
            tick_cnt_q <= tick_cnt_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
        end
    end

    assign dir      = dir_q;
    assign step     = step_q;
    assign moving   = moving_q;
    assign step_adv = step_adv_q;
    assign pos_x    = pos_x_q;
    assign pos_y    = pos_y_q;

endmodule
